// File: rtl/matmul_pkg.sv
// Shared types and helpers for the blocked matrix multiply engine.
package matmul_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DONE
   } state_t;

   // Width of a C element: full product plus headroom for K terms.
   function automatic int acc_width(input int dw, input int k);
      return 2 * dw + $clog2(k);
   endfunction

   // Index width for a dimension of n entries (never below one bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matmul_tile_seq.sv
// Tiled loop sequencer: tile_row, tile_col, k_chunk, i, j, k (outermost to innermost).
module matmul_tile_seq
   import matmul_pkg::*;
#(
   parameter int M      = 20,
   parameter int K      = 10,
   parameter int N      = 30,
   parameter int TILE_M = 5,
   parameter int TILE_N = 5,
   parameter int TILE_K = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                advance,
   input  logic                clear,
   output logic [idx_w(M)-1:0] i,
   output logic [idx_w(N)-1:0] j,
   output logic [idx_w(K)-1:0] k,
   output logic                last_k_in_chunk,
   output logic                last_mac
);

   localparam int IW_M = idx_w(M);
   localparam int IW_N = idx_w(N);
   localparam int IW_K = idx_w(K);

   localparam logic [IW_M-1:0] II_LAST = IW_M'(TILE_M - 1);
   localparam logic [IW_N-1:0] JJ_LAST = IW_N'(TILE_N - 1);
   localparam logic [IW_K-1:0] KK_LAST = IW_K'(TILE_K - 1);
   localparam logic [IW_M-1:0] IB_LAST = IW_M'(M - TILE_M);
   localparam logic [IW_N-1:0] JB_LAST = IW_N'(N - TILE_N);
   localparam logic [IW_K-1:0] KB_LAST = IW_K'(K - TILE_K);
   localparam logic [IW_M-1:0] IB_STEP = IW_M'(TILE_M);
   localparam logic [IW_N-1:0] JB_STEP = IW_N'(TILE_N);
   localparam logic [IW_K-1:0] KB_STEP = IW_K'(TILE_K);

   logic [IW_M-1:0] i_base, ii;
   logic [IW_N-1:0] j_base, jj;
   logic [IW_K-1:0] k_base, kk;

   assign i = i_base + ii;
   assign j = j_base + jj;
   assign k = k_base + kk;

   assign last_k_in_chunk = (kk == KK_LAST);
   assign last_mac = last_k_in_chunk && (jj == JJ_LAST) && (ii == II_LAST) &&
                     (k_base == KB_LAST) && (j_base == JB_LAST) && (i_base == IB_LAST);

   // Nested counters; each level rolls over into the next outer one.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         i_base <= '0;
         j_base <= '0;
         k_base <= '0;
         ii     <= '0;
         jj     <= '0;
         kk     <= '0;
      end else if (advance) begin
         if (kk != KK_LAST) begin
            kk <= kk + 1'b1;
         end else begin
            kk <= '0;
            if (jj != JJ_LAST) begin
               jj <= jj + 1'b1;
            end else begin
               jj <= '0;
               if (ii != II_LAST) begin
                  ii <= ii + 1'b1;
               end else begin
                  ii <= '0;
                  if (k_base != KB_LAST) begin
                     k_base <= k_base + KB_STEP;
                  end else begin
                     k_base <= '0;
                     if (j_base != JB_LAST) begin
                        j_base <= j_base + JB_STEP;
                     end else begin
                        j_base <= '0;
                        if (i_base != IB_LAST) i_base <= i_base + IB_STEP;
                        else                   i_base <= '0;
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/block_matmul_engine.sv
// Blocked matrix multiply engine: C = A*B or C += A*B, one MAC per cycle.
// Optional macro MATMUL_PERF_CNT_EN adds the perf_cycles busy-cycle counter.
module block_matmul_engine
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int M          = 20,
   parameter int K          = 10,
   parameter int N          = 30,
   parameter int TILE_M     = 5,
   parameter int TILE_N     = 5,
   parameter int TILE_K     = 5,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, K),
   parameter int SIGNED     = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  accumulate,
   output logic                  busy,
   output logic                  done,
   input  logic                  a_wr_en,
   input  logic [idx_w(M)-1:0]   a_wr_row,
   input  logic [idx_w(K)-1:0]   a_wr_col,
   input  logic [DATA_WIDTH-1:0] a_wr_data,
   input  logic                  b_wr_en,
   input  logic [idx_w(K)-1:0]   b_wr_row,
   input  logic [idx_w(N)-1:0]   b_wr_col,
   input  logic [DATA_WIDTH-1:0] b_wr_data,
   input  logic                  c_rd_en,
   input  logic [idx_w(M)-1:0]   c_rd_row,
   input  logic [idx_w(N)-1:0]   c_rd_col,
   output logic [ACC_WIDTH-1:0]  c_rd_data,
   output logic                  c_rd_valid
`ifdef MATMUL_PERF_CNT_EN
   ,
   output logic [31:0]           perf_cycles
`endif
);

   localparam int IW_M = idx_w(M);
   localparam int IW_N = idx_w(N);
   localparam int IW_K = idx_w(K);

   localparam logic [IW_M:0] M_LIM = (IW_M + 1)'(M);
   localparam logic [IW_N:0] N_LIM = (IW_N + 1)'(N);
   localparam logic [IW_K:0] K_LIM = (IW_K + 1)'(K);

   if ((M % TILE_M) != 0 || (N % TILE_N) != 0 || (K % TILE_K) != 0) begin : g_bad_tiling
      $error("block_matmul_engine: tile sizes must divide M, N and K");
   end

   state_t state, next_state;
   logic   mac_en, seq_clear, clear_c;

   logic [DATA_WIDTH-1:0] a_mem [M][K];
   logic [DATA_WIDTH-1:0] b_mem [K][N];
   logic [ACC_WIDTH-1:0]  c_mem [M][N];

   logic [IW_M-1:0]      si;
   logic [IW_N-1:0]      sj;
   logic [IW_K-1:0]      sk;
   logic                 last_k, last_mac;
   logic [ACC_WIDTH-1:0] acc, a_ext, b_ext, prod;

   matmul_tile_seq #(
      .M      (M),
      .K      (K),
      .N      (N),
      .TILE_M (TILE_M),
      .TILE_N (TILE_N),
      .TILE_K (TILE_K)
   ) u_seq (
      .clock           (clock),
      .reset           (reset),
      .advance         (mac_en),
      .clear           (seq_clear),
      .i               (si),
      .j               (sj),
      .k               (sk),
      .last_k_in_chunk (last_k),
      .last_mac        (last_mac)
   );

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state and control decode.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      mac_en     = 1'b0;
      seq_clear  = 1'b0;
      clear_c    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = MAC;
               seq_clear  = 1'b1;
               clear_c    = ~accumulate;
            end
         end
         MAC: begin
            busy   = 1'b1;
            mac_en = 1'b1;
            if (last_mac) next_state = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand extension to C width; the extended product equals the
   // sign/zero-extended 2*DATA_WIDTH product modulo 2^ACC_WIDTH.
   always_comb begin
      if (SIGNED != 0) begin
         a_ext = ACC_WIDTH'($signed(a_mem[si][sk]));
         b_ext = ACC_WIDTH'($signed(b_mem[sk][sj]));
      end else begin
         a_ext = ACC_WIDTH'(a_mem[si][sk]);
         b_ext = ACC_WIDTH'(b_mem[sk][sj]);
      end
      prod = a_ext * b_ext;
   end

   // Operand write ports, frozen while an operation is running.
   always_ff @(posedge clock) begin
      if (a_wr_en && !busy && ({1'b0, a_wr_row} < M_LIM) && ({1'b0, a_wr_col} < K_LIM))
         a_mem[a_wr_row][a_wr_col] <= a_wr_data;
      if (b_wr_en && !busy && ({1'b0, b_wr_row} < K_LIM) && ({1'b0, b_wr_col} < N_LIM))
         b_mem[b_wr_row][b_wr_col] <= b_wr_data;
   end

   // Chunk partial sum, flushed into C on the last k of each chunk.
   always_ff @(posedge clock) begin
      if (reset || seq_clear) acc <= '0;
      else if (mac_en)        acc <= last_k ? '0 : acc + prod;
   end

   // C array: cleared on reset or a non-accumulating start, updated once per chunk.
   always_ff @(posedge clock) begin
      if (reset || clear_c) begin
         for (int unsigned r = 0; r < M; r++)
            for (int unsigned c = 0; c < N; c++)
               c_mem[IW_M'(r)][IW_N'(c)] <= '0;
      end else if (mac_en && last_k) begin
         c_mem[si][sj] <= c_mem[si][sj] + acc + prod;
      end
   end

   // Registered C read port; out-of-range reads return zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         c_rd_valid <= 1'b0;
         c_rd_data  <= '0;
      end else begin
         c_rd_valid <= c_rd_en;
         if (c_rd_en) begin
            if (({1'b0, c_rd_row} < M_LIM) && ({1'b0, c_rd_col} < N_LIM))
               c_rd_data <= c_mem[c_rd_row][c_rd_col];
            else
               c_rd_data <= '0;
         end
      end
   end

`ifdef MATMUL_PERF_CNT_EN
   // Busy-cycle counter: cleared on accepted start, saturating, holds in IDLE.
   always_ff @(posedge clock) begin
      if (reset || seq_clear)       perf_cycles <= '0;
      else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
   end
`endif

endmodule

// File: tb/tb_block_matmul_engine.sv
// Scoreboard bench: unsigned and signed engines driven in parallel and
// compared against a plain triple-loop reference model.
module tb_block_matmul_engine;

   localparam int DW    = 8;
   localparam int M     = 20;
   localparam int K     = 10;
   localparam int N     = 30;
   localparam int ACC_W = 2 * DW + $clog2(K);
   localparam int MNK   = M * N * K;
   localparam int RW_M  = $clog2(M);
   localparam int RW_K  = $clog2(K);
   localparam int RW_N  = $clog2(N);
   localparam longint MASK = (longint'(1) << ACC_W) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic accumulate = 1'b0;
   logic a_wr_en = 1'b0, b_wr_en = 1'b0, c_rd_en = 1'b0;
   logic [RW_M-1:0] a_wr_row = '0, c_rd_row = '0;
   logic [RW_K-1:0] a_wr_col = '0, b_wr_row = '0;
   logic [RW_N-1:0] b_wr_col = '0, c_rd_col = '0;
   logic [DW-1:0]   a_wr_data = '0, b_wr_data = '0;

   logic busy_u, done_u, valid_u, busy_s, done_s, valid_s;
   logic [ACC_W-1:0] data_u, data_s;
`ifdef MATMUL_PERF_CNT_EN
   logic [31:0] perf_u, perf_s;
`endif

   always #5 clock = ~clock;

   block_matmul_engine #(.SIGNED(0)) dut_u (
      .clock(clock), .reset(reset), .start(start), .accumulate(accumulate),
      .busy(busy_u), .done(done_u),
      .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_col(a_wr_col), .a_wr_data(a_wr_data),
      .b_wr_en(b_wr_en), .b_wr_row(b_wr_row), .b_wr_col(b_wr_col), .b_wr_data(b_wr_data),
      .c_rd_en(c_rd_en), .c_rd_row(c_rd_row), .c_rd_col(c_rd_col),
      .c_rd_data(data_u), .c_rd_valid(valid_u)
`ifdef MATMUL_PERF_CNT_EN
      , .perf_cycles(perf_u)
`endif
   );

   block_matmul_engine #(.SIGNED(1)) dut_s (
      .clock(clock), .reset(reset), .start(start), .accumulate(accumulate),
      .busy(busy_s), .done(done_s),
      .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_col(a_wr_col), .a_wr_data(a_wr_data),
      .b_wr_en(b_wr_en), .b_wr_row(b_wr_row), .b_wr_col(b_wr_col), .b_wr_data(b_wr_data),
      .c_rd_en(c_rd_en), .c_rd_row(c_rd_row), .c_rd_col(c_rd_col),
      .c_rd_data(data_s), .c_rd_valid(valid_s)
`ifdef MATMUL_PERF_CNT_EN
      , .perf_cycles(perf_s)
`endif
   );

   // Reference model state (flat, row-major).
   longint ma[], mb[], cu[], cs[];
   bit     model_busy = 1'b0;

   typedef struct {
      longint eu;
      longint es;
      int     r;
      int     c;
   } rd_t;
   rd_t    rd_q[$];
   longint done_q[$];

   int     n_cmp = 0;
   int     n_err = 0;
   longint cyc = 0;
   logic   rd_en_d = 1'b0;

   always @(posedge clock) begin
      cyc     <= cyc + 1;
      rd_en_d <= reset ? 1'b0 : c_rd_en;
   end

   // Monitor: read responses and done pulses against the scoreboard queues.
   always @(negedge clock) begin
      rd_t e;
      longint exp_edge;
      if (valid_u !== rd_en_d || valid_s !== rd_en_d) begin
         n_cmp++;
         n_err++;
         $display("FAIL rd_valid: got u=%0b s=%0b want %0b", valid_u, valid_s, rd_en_d);
      end
      if (rd_en_d) begin
         n_cmp++;
         if (rd_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected: got a read response, want none pending");
         end else begin
            e = rd_q.pop_front();
            if (data_u !== ACC_W'(e.eu) || data_s !== ACC_W'(e.es)) begin
               n_err++;
               $display("FAIL rd C[%0d][%0d]: got u=%0h s=%0h want u=%0h s=%0h",
                        e.r, e.c, data_u, data_s, ACC_W'(e.eu), ACC_W'(e.es));
            end
         end
      end
      if (done_u === 1'b1 || done_s === 1'b1) begin
         n_cmp++;
         if (done_q.size() == 0) begin
            n_err++;
            $display("FAIL done_unexpected: got done at edge %0d, want none", cyc + 1);
         end else begin
            exp_edge = done_q.pop_front();
            if (done_u !== 1'b1 || done_s !== 1'b1 || cyc + 1 != exp_edge) begin
               n_err++;
               $display("FAIL done_timing: got edge %0d (u=%0b s=%0b) want edge %0d",
                        cyc + 1, done_u, done_s, exp_edge);
            end
         end
      end
   end

   function automatic longint sx(longint v);
      return (v >= (longint'(1) << (DW - 1))) ? v - (longint'(1) << DW) : v;
   endfunction

   // C = A*B (or C += A*B) straight from the definition.
   function automatic void model_op(bit acc);
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < N; j++) begin
            longint su = 0, ss = 0;
            for (int k = 0; k < K; k++) begin
               su += ma[i*K+k] * mb[k*N+j];
               ss += sx(ma[i*K+k]) * sx(mb[k*N+j]);
            end
            cu[i*N+j] = ((acc ? cu[i*N+j] : 0) + su) & MASK;
            cs[i*N+j] = ((acc ? cs[i*N+j] : 0) + ss) & MASK;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(string name, longint got, longint want);
      n_cmp++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic wr_a(int r, int c, int v);
      a_wr_en = 1'b1; a_wr_row = RW_M'(r); a_wr_col = RW_K'(c); a_wr_data = DW'(v);
      if (!model_busy && r < M && c < K) ma[r*K+c] = v;
      tick();
      a_wr_en = 1'b0;
   endtask

   task automatic wr_b(int r, int c, int v);
      b_wr_en = 1'b1; b_wr_row = RW_K'(r); b_wr_col = RW_N'(c); b_wr_data = DW'(v);
      if (!model_busy && r < K && c < N) mb[r*N+c] = v;
      tick();
      b_wr_en = 1'b0;
   endtask

   task automatic rd(int r, int c);
      rd_t e;
      c_rd_en = 1'b1; c_rd_row = RW_M'(r); c_rd_col = RW_N'(c);
      e.r = r; e.c = c;
      e.eu = (r < M && c < N) ? cu[r*N+c] : 0;
      e.es = (r < M && c < N) ? cs[r*N+c] : 0;
      rd_q.push_back(e);
      tick();
      c_rd_en = 1'b0;
   endtask

   task automatic rd_all();
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++)
            rd(r, c);
   endtask

   task automatic start_op(bit acc);
      start = 1'b1;
      accumulate = acc;
      done_q.push_back(cyc + 1 + MNK + 1);
      model_op(acc);
      model_busy = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Wait (bounded) for done; optionally raise start during the DONE cycle.
   task automatic wait_done(bit poke_start);
      int n = 0;
      while (done_u !== 1'b1 && n < MNK + 100) begin
         tick();
         n++;
      end
      if (done_u !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got no done after %0d cycles, want done", n);
      end
      if (poke_start) start = 1'b1;
      tick();
      start = 1'b0;
      model_busy = 1'b0;
   endtask

   initial begin
      ma = new[M*K];
      mb = new[K*N];
      cu = new[M*N];
      cs = new[M*N];
      foreach (cu[x]) begin cu[x] = 0; cs[x] = 0; end

      reset = 1'b1;
      repeat (3) tick();
      chk("rst_busy", {busy_u, busy_s}, 0);
      chk("rst_done", {done_u, done_s}, 0);
      chk("rst_valid", {valid_u, valid_s}, 0);
      chk("rst_data", data_u | data_s, 0);
      reset = 1'b0;
      tick();
      rd(0, 0);

      // Ramp operands, plus ignored out-of-range writes.
      for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) wr_a(i, k, i + k);
      for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) wr_b(k, j, k + j);
      wr_a(25, 0, 7);
      wr_b(0, 30, 7);
      start_op(1'b0);
      wait_done(1'b1);
`ifdef MATMUL_PERF_CNT_EN
      chk("perf_after_op", perf_u, MNK + 1);
      repeat (5) tick();
      chk("perf_idle_hold", perf_u, MNK + 1);
`endif
      rd(0, 0); rd(1, 2); rd(31, 0); rd(0, 30); rd(19, 29);

      // Start right after the poked DONE cycle must be accepted; then accumulate.
      start_op(1'b1);
      wait_done(1'b0);
      rd(0, 0); rd(1, 2); rd(7, 13);
      start_op(1'b0);
      wait_done(1'b0);
      rd(0, 0); rd(1, 2);

      // Saturated operands: exercises sign handling on every element.
      for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) wr_a(i, k, 'hFF);
      for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) wr_b(k, j, 'h02);
      start_op(1'b0);
      wait_done(1'b0);
      rd_all();

      // Reset mid-operation aborts, clears C, and never pulses done.
      start_op(1'b1);
      repeat (100) tick();
      reset = 1'b1;
      tick();
      chk("abort_busy", {busy_u, busy_s}, 0);
      reset = 1'b0;
      done_q.delete();
      model_busy = 1'b0;
      foreach (cu[x]) begin cu[x] = 0; cs[x] = 0; end
      repeat (20) tick();
      rd(0, 0); rd(5, 5);

      // Random operands; restart attempt and operand write while busy are ignored.
      for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) wr_a(i, k, int'($urandom_range(0, 255)));
      for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) wr_b(k, j, int'($urandom_range(0, 255)));
      start_op(1'($urandom_range(0, 1)));
      repeat (50) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_a(0, 0, 99);
      wait_done(1'b0);
`ifdef MATMUL_PERF_CNT_EN
      chk("perf_restart_ignored", perf_u, MNK + 1);
`endif
      rd_all();

      repeat (5) tick();
      chk("rd_queue_drained", rd_q.size(), 0);
      chk("done_queue_drained", done_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/block_matmul_engine.md
Name: block_matmul_engine

Overview:
- Parametrised successor to the fixed blocked matrix multiplier. Computes C = A×B, or C += A×B, with A of size M×K and B of size K×N.
- Loop order is tiled: TILE_M×TILE_N output tiles, K consumed in TILE_K chunks.
- Internal A/B/C register arrays; write ports load A and B, a read port reads C; start/busy/done handshake.
- Sits between the host load/unload logic and downstream consumers in the matmul datapath.

Parameters:
DATA_WIDTH, 8, operand width
M, 20, rows of A / C
K, 10, inner dimension
N, 30, columns of B / C
TILE_M, 5, output tile rows; M % TILE_M == 0, elaboration error otherwise
TILE_N, 5, output tile cols; N % TILE_N == 0
TILE_K, 5, inner chunk; K % TILE_K == 0
ACC_WIDTH, 2*DATA_WIDTH+$clog2(K), C element width
SIGNED, 0, 1 = two's-complement operands and products

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous reset, active-high
start  in  1  begin operation; sampled only in IDLE
accumulate  in  1  sampled with start; 0 = clear C first, 1 = add into C
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
a_wr_en  in  1  write A[a_wr_row][a_wr_col]
a_wr_row  in  $clog2(M)  A row
a_wr_col  in  $clog2(K)  A col
a_wr_data  in  DATA_WIDTH  A element
b_wr_en  in  1  write B[b_wr_row][b_wr_col]
b_wr_row  in  $clog2(K)  B row
b_wr_col  in  $clog2(N)  B col
b_wr_data  in  DATA_WIDTH  B element
c_rd_en  in  1  read C[c_rd_row][c_rd_col]
c_rd_row  in  $clog2(M)  C row
c_rd_col  in  $clog2(N)  C col
c_rd_data  out  ACC_WIDTH  C element, 1-cycle latency
c_rd_valid  out  1  high the cycle c_rd_data is valid

Behaviour:
- Reset values: busy=0, done=0, c_rd_valid=0, c_rd_data=0, FSM=IDLE, all C elements and loop counters =0. A/B arrays are not reset.
- FSM states: IDLE, MAC, DONE.
  - IDLE: on start=1, latch accumulate. If accumulate=0, clear all of C in that same edge. Go to MAC.
  - MAC: exactly one MAC per cycle, lasting M*N*K cycles.
  - DONE: one cycle with done=1, then IDLE.
- busy=1 in MAC and DONE states.
- Start-to-done latency: start sampled at edge t; done high during cycle t+M*N*K+1.
- Loop order, outermost to innermost: tile_row, tile_col, k_chunk, i in tile, j in tile, k in chunk.
- Each MAC cycle: prod = A[i][k]*B[k][j] at 2*DATA_WIDTH, signed or unsigned per SIGNED.
  - Not last k of chunk: acc <= acc + prod.
  - Last k of chunk: C[i][j] <= C[i][j] + acc + prod, and acc <= 0.
  - No C read-after-write hazard: one C write per (i,j) per chunk, and there are no back-to-back writes to the same element.
- All sums wrap modulo 2^ACC_WIDTH. Products are sign- or zero-extended to ACC_WIDTH.
- start while busy is ignored (no restart, no queued op).
- a_wr_en/b_wr_en while busy are ignored (operands frozen).
- Out-of-range indices: writes ignored; reads return 0 with c_rd_valid=1.
- c_rd_en while busy: allowed; returns the current partial C value.
- Reset mid-operation: immediate abort to IDLE, C cleared, done never pulses for the aborted op.
- done and start in the same cycle: start ignored, because the FSM is in DONE; a start in the following IDLE cycle is accepted.

Optional Feature:
- Macro: MATMUL_PERF_CNT_EN.
- Defined: adds output perf_cycles [31:0].
  - Cleared when start is accepted.
  - Increments every busy cycle.
  - Holds its value in IDLE, saturating at 0xFFFFFFFF.
  - Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package matmul_pkg:
  - FSM state enum (IDLE/MAC/DONE).
  - acc_width(dw,k) constant function.
  - Shared index-width localparam helpers.
- Sub-module matmul_tile_seq:
  - Nested tile/chunk/element counters.
  - Outputs i, j, k, last_k_in_chunk, last_mac.
  - Inputs: advance, clear.

Test Plan:
- Defaults, A[i][k]=i+k, B[k][j]=k+j, start with accumulate=0 -> done exactly 6001 cycles after start edge; C[0][0]=285, C[1][2]=440; each read has c_rd_valid 1 cycle after c_rd_en.
- Repeat the same op with accumulate=1 -> C[0][0]=570, C[1][2]=880; a further op with accumulate=0 -> C[0][0]=285.
- All A=0xFF, all B=0x02: SIGNED=0 -> every C=5100; SIGNED=1 -> every C=0xFFFEC (-20, 20-bit).
- Assert reset 100 cycles after start -> busy=0 next cycle, no done pulse, C[0][0] reads 0.
- Pulse start again 50 cycles into an op, and write A[0][0]=99 while busy -> single done at cycle 6001; results match unmodified A.
- Feature on: after the defaults run, perf_cycles=6001 and stays stable in IDLE; read of C[31][0] (out of range) -> 0 with valid.
